// File: rtl/pipelined_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the pipelined control unit: MIPS opcode and funct
// encodings, the ALU operation enumeration, memory access width codes, the
// packed EX control bundle and the instruction decode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cu_pkg;

   // Primary opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_LWU   = 6'b100111;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes, instr[5:0]
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_MULT = 6'b011000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   // Data memory access width
   localparam logic [1:0] MEM_WORD = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_BYTE = 2'd2;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_SRA  = 4'd2,
      ALU_ADD  = 4'd3,
      ALU_SUB  = 4'd4,
      ALU_AND  = 4'd5,
      ALU_OR   = 4'd6,
      ALU_XOR  = 4'd7,
      ALU_NOR  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_MUL  = 4'd10,
      ALU_RSVD = 4'd15
   } alu_op_t;

   // Control fields carried in the ID/EX register
   typedef struct packed {
      logic       branch;
      logic       branch_ne;
      logic       mem_to_reg;
      logic       alu_src;
      logic       shift_imm;
      logic       reg_write;
      logic       load_imm;
      logic       zero_ex;
      logic       mem_sign_ext;
      logic [1:0] mem_width;
      alu_op_t    alu_op;
   } ctrl_t;

   // Decode result: the EX bundle plus ID-stage-only information
   typedef struct packed {
      ctrl_t ctrl;
      logic  reg_dst;
      logic  mem_write;
      logic  illegal;
      logic  uses_rs;
      logic  uses_rt;
      logic  is_mult;
   } dec_t;

   // Opcode/funct to control bundle. An undecodable instruction comes back
   // with illegal set and an all-zero bundle so it can only ever be a bubble.
   function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
      dec_t d;
      d         = '0;
      d.uses_rs = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            d.uses_rt        = 1'b1;
            d.reg_dst        = 1'b1;
            d.ctrl.reg_write = 1'b1;
            case (funct)
               FN_SLL:  begin d.ctrl.alu_op = ALU_SLL; d.ctrl.shift_imm = 1'b1; d.uses_rs = 1'b0; end
               FN_SRL:  begin d.ctrl.alu_op = ALU_SRL; d.ctrl.shift_imm = 1'b1; d.uses_rs = 1'b0; end
               FN_SRA:  begin d.ctrl.alu_op = ALU_SRA; d.ctrl.shift_imm = 1'b1; d.uses_rs = 1'b0; end
               FN_ADD:  d.ctrl.alu_op = ALU_ADD;
               FN_SUB:  d.ctrl.alu_op = ALU_SUB;
               FN_AND:  d.ctrl.alu_op = ALU_AND;
               FN_OR:   d.ctrl.alu_op = ALU_OR;
               FN_XOR:  d.ctrl.alu_op = ALU_XOR;
               FN_NOR:  d.ctrl.alu_op = ALU_NOR;
               FN_SLT:  d.ctrl.alu_op = ALU_SLT;
               FN_MULT: begin d.ctrl.alu_op = ALU_MUL; d.is_mult = 1'b1; end
               default: d.illegal = 1'b1;
            endcase
         end
         OP_BEQ, OP_BNE: begin
            d.uses_rt        = 1'b1;
            d.ctrl.branch    = 1'b1;
            d.ctrl.branch_ne = (opcode == OP_BNE);
            d.ctrl.alu_op    = ALU_SUB;
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
            d.ctrl.alu_src   = 1'b1;
            d.ctrl.reg_write = 1'b1;
            d.ctrl.zero_ex   = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
            case (opcode)
               OP_SLTI: d.ctrl.alu_op = ALU_SLT;
               OP_ANDI: d.ctrl.alu_op = ALU_AND;
               OP_ORI:  d.ctrl.alu_op = ALU_OR;
               OP_XORI: d.ctrl.alu_op = ALU_XOR;
               default: d.ctrl.alu_op = ALU_ADD;
            endcase
         end
         OP_LUI: begin
            d.uses_rs        = 1'b0;
            d.ctrl.alu_src   = 1'b1;
            d.ctrl.reg_write = 1'b1;
            d.ctrl.load_imm  = 1'b1;
            d.ctrl.alu_op    = ALU_ADD;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
            d.ctrl.alu_src      = 1'b1;
            d.ctrl.alu_op       = ALU_ADD;
            d.ctrl.mem_to_reg   = 1'b1;
            d.ctrl.reg_write    = 1'b1;
            d.ctrl.mem_sign_ext = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW);
            if ((opcode == OP_LB) || (opcode == OP_LBU))
               d.ctrl.mem_width = MEM_BYTE;
            else if ((opcode == OP_LH) || (opcode == OP_LHU))
               d.ctrl.mem_width = MEM_HALF;
            else
               d.ctrl.mem_width = MEM_WORD;
         end
         OP_SB, OP_SH, OP_SW: begin
            d.uses_rt        = 1'b1;
            d.ctrl.alu_src   = 1'b1;
            d.ctrl.alu_op    = ALU_ADD;
            d.mem_write      = 1'b1;
            if (opcode == OP_SB)
               d.ctrl.mem_width = MEM_BYTE;
            else if (opcode == OP_SH)
               d.ctrl.mem_width = MEM_HALF;
            else
               d.ctrl.mem_width = MEM_WORD;
         end
         default: d.illegal = 1'b1;
      endcase
      if (d.illegal) begin
         d.ctrl      = '0;
         d.reg_dst   = 1'b0;
         d.mem_write = 1'b0;
         d.is_mult   = 1'b0;
      end
      return d;
   endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit_if
// Bundles the ID-stage instruction fields, the branch flush, the hazard
// outputs and the registered EX control bundle.
//   master : drives id_* and flush, observes stall/illegal/ex_*
//   slave  : the control unit itself
// ---------------------------------------------------------------------------
interface pipelined_control_unit_if #(
   parameter int REG_ADDR_W = 5,
   parameter int MEM_WE_W   = 4
);
   logic                  id_valid;
   logic [5:0]            id_opcode;
   logic [5:0]            id_funct;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  flush;

   logic                  stall;
   logic                  illegal;
   logic                  ex_valid;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic                  ex_branch;
   logic                  ex_branch_ne;
   logic                  ex_mem_to_reg;
   logic                  ex_alu_src;
   logic                  ex_shift_imm;
   logic                  ex_reg_write;
   logic                  ex_load_imm;
   logic                  ex_zero_ex;
   logic                  ex_mem_sign_ext;
   logic [MEM_WE_W-1:0]   ex_mem_write;
   logic [1:0]            ex_mem_width;
   logic [3:0]            ex_alu_op;

   modport master (
      output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, flush,
      input  stall, illegal, ex_valid, ex_dest, ex_branch, ex_branch_ne,
             ex_mem_to_reg, ex_alu_src, ex_shift_imm, ex_reg_write, ex_load_imm,
             ex_zero_ex, ex_mem_sign_ext, ex_mem_write, ex_mem_width, ex_alu_op
   );

   modport slave (
      input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, flush,
      output stall, illegal, ex_valid, ex_dest, ex_branch, ex_branch_ne,
             ex_mem_to_reg, ex_alu_src, ex_shift_imm, ex_reg_write, ex_load_imm,
             ex_zero_ex, ex_mem_sign_ext, ex_mem_write, ex_mem_width, ex_alu_op
   );
endinterface

// File: rtl/pipelined_control_unit_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational hazard logic for the control unit.
//   i_exValid, i_exMemToReg, i_exDest : instruction currently in EX
//   i_idValid, i_idRs, i_idRt         : instruction currently in ID
//   i_usesRs, i_usesRt                : which ID sources are really read
//   i_busyCnt                         : remaining MULT occupancy of EX
//   o_loadUse                         : ID needs a load result not yet loaded
//   o_stall                           : freeze PC and IF/ID
// ---------------------------------------------------------------------------
module hazard_detect #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_exValid,
   input  logic                  i_exMemToReg,
   input  logic [REG_ADDR_W-1:0] i_exDest,
   input  logic                  i_idValid,
   input  logic [REG_ADDR_W-1:0] i_idRs,
   input  logic [REG_ADDR_W-1:0] i_idRt,
   input  logic                  i_usesRs,
   input  logic                  i_usesRt,
   input  logic [3:0]            i_busyCnt,
   output logic                  o_loadUse,
   output logic                  o_stall
);

   // A load into r0 never produces a value anyone waits for, so it is
   // excluded; only sources the ID instruction actually reads count.
   always_comb begin
      o_loadUse = i_exValid & i_exMemToReg & (i_exDest != '0) & i_idValid &
                  ((i_usesRs & (i_exDest == i_idRs)) | (i_usesRt & (i_exDest == i_idRt)));
      o_stall   = o_loadUse | (i_busyCnt != 4'd0);
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
// Decodes the ID-stage instruction into the EX control bundle and holds it in
// the ID/EX control register, inserting bubbles for load-use hazards, branch
// flushes and illegal instructions, and holding EX while a MULT is busy.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_control_unit_if (ID fields, flush,
//           stall, illegal, ex_* bundle)
// ---------------------------------------------------------------------------
module pipelined_control_unit
   import cu_pkg::*;
#(
   parameter int REG_ADDR_W   = 5,
   parameter int MEM_WE_W     = 4,
   parameter int MULT_LATENCY = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pipelined_control_unit_if.slave  bus
);

   localparam logic [3:0] BUSY_INIT = 4'(MULT_LATENCY - 1);

   dec_t                  w_dec;
   ctrl_t                 w_decCtrl;
   logic [REG_ADDR_W-1:0] w_decDest;
   logic [MEM_WE_W-1:0]   w_decMemWe;
   logic                  w_loadUse;
   logic                  w_stall;

   ctrl_t                 r_exCtrl;
   logic                  r_exValid;
   logic [REG_ADDR_W-1:0] r_exDest;
   logic [MEM_WE_W-1:0]   r_exMemWe;
   logic [3:0]            r_busyCnt;
   logic                  r_illegal;

   // Decode the ID instruction; a write to r0 is dropped here so it never
   // reaches write-back, and store strobes are widened to the bus width.
   always_comb begin
      w_dec     = decode(bus.id_opcode, bus.id_funct);
      w_decDest = w_dec.reg_dst ? bus.id_rd : bus.id_rt;
      w_decCtrl = w_dec.ctrl;
      w_decCtrl.reg_write = w_dec.ctrl.reg_write & (w_decDest != '0);
      w_decMemWe = '0;
      if (w_dec.mem_write) begin
         case (w_dec.ctrl.mem_width)
            MEM_BYTE: w_decMemWe = MEM_WE_W'(1);
            MEM_HALF: w_decMemWe = MEM_WE_W'(3);
            default:  w_decMemWe = '1;
         endcase
      end
   end

   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .i_exValid    (r_exValid),
      .i_exMemToReg (r_exCtrl.mem_to_reg),
      .i_exDest     (r_exDest),
      .i_idValid    (bus.id_valid),
      .i_idRs       (bus.id_rs),
      .i_idRt       (bus.id_rt),
      .i_usesRs     (w_dec.uses_rs),
      .i_usesRt     (w_dec.uses_rt),
      .i_busyCnt    (r_busyCnt),
      .o_loadUse    (w_loadUse),
      .o_stall      (w_stall)
   );

   // ID/EX control register. Flush beats everything (including a busy MULT),
   // then a busy MULT freezes EX, then a load-use inserts a bubble, otherwise
   // the decoded instruction advances. Illegal or empty ID slots become
   // bubbles. The illegal flag reports only instructions that would really
   // have advanced this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exCtrl  <= '0;
         r_exValid <= 1'b0;
         r_exDest  <= '0;
         r_exMemWe <= '0;
         r_busyCnt <= 4'd0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= bus.id_valid & w_dec.illegal & ~w_stall & ~bus.flush;
         if (bus.flush) begin
            r_exCtrl  <= '0;
            r_exValid <= 1'b0;
            r_exDest  <= '0;
            r_exMemWe <= '0;
            r_busyCnt <= 4'd0;
         end else if (r_busyCnt != 4'd0) begin
            r_busyCnt <= r_busyCnt - 4'd1;
         end else if (w_loadUse || !bus.id_valid || w_dec.illegal) begin
            r_exCtrl  <= '0;
            r_exValid <= 1'b0;
            r_exDest  <= '0;
            r_exMemWe <= '0;
         end else begin
            r_exCtrl  <= w_decCtrl;
            r_exValid <= 1'b1;
            r_exDest  <= w_decDest;
            r_exMemWe <= w_decMemWe;
            r_busyCnt <= w_dec.is_mult ? BUSY_INIT : 4'd0;
         end
      end
   end

   assign bus.stall           = w_stall;
   assign bus.illegal         = r_illegal;
   assign bus.ex_valid        = r_exValid;
   assign bus.ex_dest         = r_exDest;
   assign bus.ex_branch       = r_exCtrl.branch;
   assign bus.ex_branch_ne    = r_exCtrl.branch_ne;
   assign bus.ex_mem_to_reg   = r_exCtrl.mem_to_reg;
   assign bus.ex_alu_src      = r_exCtrl.alu_src;
   assign bus.ex_shift_imm    = r_exCtrl.shift_imm;
   assign bus.ex_reg_write    = r_exCtrl.reg_write;
   assign bus.ex_load_imm     = r_exCtrl.load_imm;
   assign bus.ex_zero_ex      = r_exCtrl.zero_ex;
   assign bus.ex_mem_sign_ext = r_exCtrl.mem_sign_ext;
   assign bus.ex_mem_write    = r_exMemWe;
   assign bus.ex_mem_width    = r_exCtrl.mem_width;
   assign bus.ex_alu_op       = r_exCtrl.alu_op;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
// Directed-vector bench for pipelined_control_unit with MULT_LATENCY = 3.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_LBU  = 6'b100100;
   localparam logic [5:0] OP_SB   = 6'b101000;
   localparam logic [5:0] OP_SH   = 6'b101001;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BAD  = 6'b111111;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_BAD   = 6'b111111;

   logic clk;
   logic rst_n;
   int   checkCount;
   int   passCount;

   pipelined_control_unit_if #(.REG_ADDR_W(5), .MEM_WE_W(4)) bus ();

   pipelined_control_unit #(
      .REG_ADDR_W   (5),
      .MEM_WE_W     (4),
      .MULT_LATENCY (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one instruction in ID together with the flush input
   task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic fl);
      bus.id_valid  = valid;
      bus.id_opcode = op;
      bus.id_funct  = fn;
      bus.id_rs     = rs;
      bus.id_rt     = rt;
      bus.id_rd     = rd;
      bus.flush     = fl;
      #1;
   endtask

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   // Advance one clock and settle just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin
      checkCount = 0;
      passCount  = 0;
      rst_n      = 1'b0;
      idle();
      checkOutput("stall_in_reset", {31'd0, bus.stall}, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;

      // Idle after reset
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("idle_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      end
      checkOutput("idle_alu_op",    {28'd0, bus.ex_alu_op}, 32'd0);
      checkOutput("idle_mem_write", {28'd0, bus.ex_mem_write}, 32'd0);
      checkOutput("idle_dest",      {27'd0, bus.ex_dest}, 32'd0);
      checkOutput("idle_reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
      checkOutput("idle_stall",     {31'd0, bus.stall}, 32'd0);
      checkOutput("idle_illegal",   {31'd0, bus.illegal}, 32'd0);

      // LW r5 then dependent ADD r7 = r5 + r6
      applyStimulus(1'b1, OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0);
      checkOutput("lw_no_stall", {31'd0, bus.stall}, 32'd0);
      step();
      checkOutput("lw_valid",    {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("lw_mem2reg",  {31'd0, bus.ex_mem_to_reg}, 32'd1);
      checkOutput("lw_dest",     {27'd0, bus.ex_dest}, 32'd5);
      checkOutput("lw_sign_ext", {31'd0, bus.ex_mem_sign_ext}, 32'd1);
      applyStimulus(1'b1, OP_R, F_ADD, 5'd5, 5'd6, 5'd7, 1'b0);
      checkOutput("lu_stall", {31'd0, bus.stall}, 32'd1);
      step();
      checkOutput("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("lu_bubble_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
      checkOutput("lu_stall_1cyc",   {31'd0, bus.stall}, 32'd0);
      step();
      checkOutput("add_valid",  {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("add_alu_op", {28'd0, bus.ex_alu_op}, 32'd3);
      checkOutput("add_dest",   {27'd0, bus.ex_dest}, 32'd7);
      checkOutput("add_rw",     {31'd0, bus.ex_reg_write}, 32'd1);

      // LW into r0 followed by reader of r0: no hazard, no write
      applyStimulus(1'b1, OP_LW, 6'd0, 5'd2, 5'd0, 5'd0, 1'b0);
      step();
      checkOutput("lw0_valid", {31'd0, bus.ex_valid}, 32'd1);
      checkOutput("lw0_rw",    {31'd0, bus.ex_reg_write}, 32'd0);
      applyStimulus(1'b1, OP_R, F_ADD, 5'd0, 5'd3, 5'd4, 1'b0);
      checkOutput("lw0_no_stall", {31'd0, bus.stall}, 32'd0);
      step();
      checkOutput("lw0_add_dest", {27'd0, bus.ex_dest}, 32'd4);

      // MULT then OR: two stall cycles holding MUL in EX
      applyStimulus(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 5'd8, 1'b0);
      step();
      checkOutput("mult_alu_op", {28'd0, bus.ex_alu_op}, 32'd10);
      checkOutput("mult_dest",   {27'd0, bus.ex_dest}, 32'd8);
      applyStimulus(1'b1, OP_R, F_OR, 5'd3, 5'd4, 5'd9, 1'b0);
      checkOutput("mult_stall1", {31'd0, bus.stall}, 32'd1);
      step();
      checkOutput("mult_hold1",  {28'd0, bus.ex_alu_op}, 32'd10);
      checkOutput("mult_stall2", {31'd0, bus.stall}, 32'd1);
      step();
      checkOutput("mult_hold2",  {28'd0, bus.ex_alu_op}, 32'd10);
      checkOutput("mult_stall3", {31'd0, bus.stall}, 32'd0);
      step();
      checkOutput("or_alu_op", {28'd0, bus.ex_alu_op}, 32'd6);
      checkOutput("or_dest",   {27'd0, bus.ex_dest}, 32'd9);

      // Flush during a busy MULT
      applyStimulus(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 5'd8, 1'b0);
      step();
      applyStimulus(1'b1, OP_R, F_OR, 5'd3, 5'd4, 5'd9, 1'b1);
      checkOutput("fmul_stall_before", {31'd0, bus.stall}, 32'd1);
      step();
      applyStimulus(1'b1, OP_R, F_OR, 5'd3, 5'd4, 5'd9, 1'b0);
      checkOutput("fmul_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("fmul_stall", {31'd0, bus.stall}, 32'd0);
      step();
      checkOutput("fmul_or_next", {28'd0, bus.ex_alu_op}, 32'd6);

      // Flush together with a load-use
      applyStimulus(1'b1, OP_LW, 6'd0, 5'd1, 5'd5, 5'd0, 1'b0);
      step();
      applyStimulus(1'b1, OP_R, F_ADD, 5'd5, 5'd6, 5'd7, 1'b1);
      checkOutput("flu_stall_before", {31'd0, bus.stall}, 32'd1);
      step();
      applyStimulus(1'b1, OP_R, F_ADD, 5'd5, 5'd6, 5'd7, 1'b0);
      checkOutput("flu_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("flu_stall", {31'd0, bus.stall}, 32'd0);

      // Illegal opcode and illegal funct
      applyStimulus(1'b1, OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
      step();
      checkOutput("ill_pulse", {31'd0, bus.illegal}, 32'd1);
      checkOutput("ill_valid", {31'd0, bus.ex_valid}, 32'd0);
      idle();
      step();
      checkOutput("ill_one_cycle", {31'd0, bus.illegal}, 32'd0);
      applyStimulus(1'b1, OP_R, F_BAD, 5'd1, 5'd2, 5'd3, 1'b0);
      step();
      checkOutput("illfn_pulse", {31'd0, bus.illegal}, 32'd1);
      checkOutput("illfn_rw",    {31'd0, bus.ex_reg_write}, 32'd0);

      // Memory widths and strobes
      applyStimulus(1'b1, OP_LBU, 6'd0, 5'd1, 5'd3, 5'd0, 1'b0);
      step();
      checkOutput("lbu_width",    {30'd0, bus.ex_mem_width}, 32'd2);
      checkOutput("lbu_sign_ext", {31'd0, bus.ex_mem_sign_ext}, 32'd0);
      checkOutput("lbu_illegal",  {31'd0, bus.illegal}, 32'd0);
      applyStimulus(1'b1, OP_SH, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      checkOutput("sh_strobe", {28'd0, bus.ex_mem_write}, 32'h3);
      checkOutput("sh_width",  {30'd0, bus.ex_mem_width}, 32'd1);
      checkOutput("sh_rw",     {31'd0, bus.ex_reg_write}, 32'd0);
      applyStimulus(1'b1, OP_SB, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      checkOutput("sb_strobe", {28'd0, bus.ex_mem_write}, 32'h1);
      applyStimulus(1'b1, OP_SW, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      checkOutput("sw_strobe", {28'd0, bus.ex_mem_write}, 32'hf);

      // Immediate and branch flags
      applyStimulus(1'b1, OP_ANDI, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      checkOutput("andi_zero_ex", {31'd0, bus.ex_zero_ex}, 32'd1);
      checkOutput("andi_alu_op",  {28'd0, bus.ex_alu_op}, 32'd5);
      applyStimulus(1'b1, OP_BNE, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      checkOutput("bne_branch", {31'd0, bus.ex_branch}, 32'd1);
      checkOutput("bne_ne",     {31'd0, bus.ex_branch_ne}, 32'd1);

      // Reset in the middle of a MULT
      applyStimulus(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 5'd8, 1'b0);
      step();
      applyStimulus(1'b1, OP_R, F_OR, 5'd3, 5'd4, 5'd9, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
      idle();
      step();
      rst_n = 1'b1;
      step();
      checkOutput("rst_after_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("rst_after_stall", {31'd0, bus.stall}, 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
